string_hw_v2: RTL

Parametrised second-generation string.h accelerator for the Nios II custom-peripheral path. It latches operands on a go/done level handshake, validates the request, and executes one of six string functions. Functions are length-aware: bytes past `length` are ignored on input and zeroed on output. Search is iterative, testing one candidate position per cycle with early exit. It adds strcmp-style ordering, occurrence count, an error flag and a busy flag.

---
 rtl/string_hw_v2.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/string_hw_v2.sv
// String accelerator: compare, case convert, reverse, substring search and byte count.
// Operands are latched on go; search tests one candidate position per cycle.
module string_hw_v2 #(
   parameter int MAX_BYTES = 32,
   parameter int LW        = $clog2(MAX_BYTES + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         go,
   input  logic [2:0]                   op,
   input  logic [LW-1:0]                length,
   input  logic [LW-1:0]                pat_len,
   input  logic [0:MAX_BYTES-1][7:0]    A,
   input  logic [0:MAX_BYTES-1][7:0]    B,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic [15:0]                  value,
   output logic [0:MAX_BYTES-1][7:0]    Result
);

   // state   | meaning
   // IDLE    | outputs zero, waiting for go
   // CHECK   | validate latched request
   // EXEC    | single-cycle CMP/UPPER/LOWER/REV/COUNT
   // SCAN    | test candidate position pos for a pattern match
   // DONE    | result held until go drops
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_SCAN  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [2:0] OP_CMP    = 3'd0;
   localparam logic [2:0] OP_UPPER  = 3'd1;
   localparam logic [2:0] OP_LOWER  = 3'd2;
   localparam logic [2:0] OP_REV    = 3'd3;
   localparam logic [2:0] OP_SEARCH = 3'd4;
   localparam logic [2:0] OP_COUNT  = 3'd5;

   logic [2:0]                   state;
   logic [2:0]                   op_r;
   logic [LW-1:0]                len_r;
   logic [LW-1:0]                plen_r;
   logic [LW-1:0]                pos;
   logic [0:MAX_BYTES-1][7:0]    a_r;
   logic [0:MAX_BYTES-1][7:0]    b_r;

   int                           len_i;
   int                           plen_i;
   int                           pos_i;
   logic                         req_bad;
   logic                         hit;
   logic                         last_pos;
   logic [0:MAX_BYTES-1][7:0]    a_shift;
   logic [0:MAX_BYTES-1][7:0]    rev_full;
   logic [0:MAX_BYTES-1][7:0]    rev_shift;
   logic [LW+2:0]                rev_shamt;
   logic                         cmp_found;
   int                           cnt;
   logic [15:0]                  exec_value;
   logic [0:MAX_BYTES-1][7:0]    exec_result;

   always_comb begin
      len_i   = int'(len_r);
      plen_i  = int'(plen_r);
      pos_i   = int'(pos);
      req_bad = (op_r > OP_COUNT) || (len_i == 0) || (len_i > MAX_BYTES) ||
                ((op_r == OP_SEARCH) && ((plen_i == 0) || (plen_i > len_i)));
   end

   // Shifting A left by pos bytes lines the candidate window up with B[0..].
   always_comb begin
      a_shift  = a_r << {pos, 3'b000};
      hit      = 1'b1;
      for (int j = 0; j < MAX_BYTES; j++) begin
         if ((j < plen_i) && (a_shift[j] != b_r[j]))
            hit = 1'b0;
      end
      last_pos = (pos_i == (len_i - plen_i));
   end

   // Reverse the whole buffer, then shift out the MAX_BYTES-length unused bytes.
   always_comb begin
      rev_shamt   = {LW'(MAX_BYTES) - len_r, 3'b000};
      rev_full    = '0;
      for (int i = 0; i < MAX_BYTES; i++)
         rev_full[i] = a_r[MAX_BYTES-1-i];
      rev_shift   = rev_full << rev_shamt;
      exec_value  = '0;
      exec_result = '0;
      cmp_found   = 1'b0;
      cnt         = 0;
      case (op_r)
         OP_CMP: begin
            for (int i = 0; i < MAX_BYTES; i++) begin
               if (!cmp_found && (i < len_i) && (a_r[i] != b_r[i])) begin
                  cmp_found  = 1'b1;
                  exec_value = (a_r[i] > b_r[i]) ? 16'h0001 : 16'hFFFF;
               end
            end
         end
         OP_UPPER: begin
            for (int i = 0; i < MAX_BYTES; i++) begin
               if (i < len_i)
                  exec_result[i] = ((a_r[i] >= 8'h61) && (a_r[i] <= 8'h7A)) ? a_r[i] - 8'd32 : a_r[i];
            end
         end
         OP_LOWER: begin
            for (int i = 0; i < MAX_BYTES; i++) begin
               if (i < len_i)
                  exec_result[i] = ((a_r[i] >= 8'h41) && (a_r[i] <= 8'h5A)) ? a_r[i] + 8'd32 : a_r[i];
            end
         end
         OP_REV: begin
            for (int i = 0; i < MAX_BYTES; i++) begin
               if (i < len_i)
                  exec_result[i] = rev_shift[i];
            end
         end
         OP_COUNT: begin
            for (int i = 0; i < MAX_BYTES; i++) begin
               if ((i < len_i) && (a_r[i] == b_r[0]))
                  cnt = cnt + 1;
            end
            exec_value = 16'(cnt);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= S_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         value  <= '0;
         Result <= '0;
         op_r   <= '0;
         len_r  <= '0;
         plen_r <= '0;
         pos    <= '0;
         a_r    <= '0;
         b_r    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (go) begin
                  op_r   <= op;
                  len_r  <= length;
                  plen_r <= pat_len;
                  a_r    <= A;
                  b_r    <= B;
                  busy   <= 1'b1;
                  state  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (req_bad) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else if (op_r == OP_SEARCH) begin
                  pos   <= '0;
                  state <= S_SCAN;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               value  <= exec_value;
               Result <= exec_result;
               busy   <= 1'b0;
               done   <= 1'b1;
               state  <= S_DONE;
            end
            S_SCAN: begin
               if (hit || last_pos) begin
                  value <= hit ? 16'(pos) : 16'hFFFF;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  pos <= pos + 1'b1;
               end
            end
            S_DONE: begin
               if (!go) begin
                  done   <= 1'b0;
                  err    <= 1'b0;
                  value  <= '0;
                  Result <= '0;
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
